// File: rtl/globals_pkg.sv
// Shared MMIO register map, counter ordering and request record used by the
// host-facing register responder.
package globals_pkg;

    localparam int NUM_COUNTERS = 11;

    // Counter slot order inside counters_in, slot 0 in the least significant 64 bits
    localparam int CNT_DONE          = 0;
    localparam int CNT_DONE_RESTART  = 1;
    localparam int CNT_DONE_PREFETCH = 2;
    localparam int CNT_PAGED         = 3;
    localparam int CNT_FLUSHED       = 4;
    localparam int CNT_AERROR        = 5;
    localparam int CNT_DERROR        = 6;
    localparam int CNT_FAILED        = 7;
    localparam int CNT_FAULT         = 8;
    localparam int CNT_NRES          = 9;
    localparam int CNT_NLOCK         = 10;

    localparam logic [23:0] ADDR_ALGO_STATUS          = 24'hFFFFFE;
    localparam logic [23:0] ADDR_ALGO_REQUEST         = 24'hFFFFFC;
    localparam logic [23:0] ADDR_ERROR_REG            = 24'hFFFFFA;
    localparam logic [23:0] ADDR_AFU_STATUS           = 24'hFFFFF8;
    localparam logic [23:0] ADDR_ALGO_RUNNING         = 24'hFFFFF6;
    localparam logic [23:0] ADDR_ALGO_STATUS_ACK      = 24'hFFFFF4;
    localparam logic [23:0] ADDR_ERROR_REG_ACK        = 24'hFFFFF2;
    localparam logic [23:0] ADDR_ALGO_STATUS_DONE     = 24'hFFFFF0;
    localparam logic [23:0] ADDR_ALGO_STATUS_DONE_ACK = 24'hFFFFEE;
    localparam logic [23:0] ADDR_DONE_COUNT           = 24'hFFFFEC;
    localparam logic [23:0] ADDR_DONE_RESTART         = 24'hFFFFEA;
    localparam logic [23:0] ADDR_PAGED                = 24'hFFFFE8;
    localparam logic [23:0] ADDR_FLUSHED              = 24'hFFFFE6;
    localparam logic [23:0] ADDR_AERROR               = 24'hFFFFE4;
    localparam logic [23:0] ADDR_DERROR               = 24'hFFFFE2;
    localparam logic [23:0] ADDR_FAILED               = 24'hFFFFE0;
    localparam logic [23:0] ADDR_FAULT                = 24'hFFFFDE;
    localparam logic [23:0] ADDR_NRES                 = 24'hFFFFDC;
    localparam logic [23:0] ADDR_NLOCK                = 24'hFFFFDA;
    localparam logic [23:0] ADDR_DONE_PREFETCH        = 24'hFFFFD8;

    typedef struct packed {
        logic        cfg;
        logic        read;
        logic        dw;
        logic [23:0] addr;
        logic [63:0] data;
    } mmio_req_t;

    function automatic logic odd_parity(input logic [63:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/mmio_register_responder.sv
// Host MMIO responder: two-stage fixed-latency decode of the AFU register map,
// forwarding host writes to CU control as single-cycle strobes.
module mmio_register_responder #(
    parameter logic [63:0] AFU_DESCRIPTOR = 64'h0000_0000_0001_0001,
    parameter int          NUM_COUNTERS   = globals_pkg::NUM_COUNTERS
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      mmio_in_valid,
    input  logic                      mmio_in_cfg,
    input  logic                      mmio_in_read,
    input  logic                      mmio_in_dw,
    input  logic [23:0]               mmio_in_addr,
    input  logic [63:0]               mmio_in_data,
    output logic                      mmio_ack,
    output logic [63:0]               mmio_rdata,
    output logic                      mmio_rdata_parity,
    output logic [63:0]               algo_request,
    output logic                      algo_request_valid,
    input  logic [63:0]               algo_status_in,
    input  logic                      algo_status_valid_in,
    input  logic                      algo_done_in,
    input  logic                      afu_running_in,
    input  logic [63:0]               error_in,
    input  logic [64*NUM_COUNTERS-1:0] counters_in,
    output logic                      protocol_error
);
    import globals_pkg::*;

    mmio_req_t   req_p1;
    logic        vld_p1;
    logic        busy;
    logic [63:0] status_reg;
    logic [63:0] error_reg;
    logic        done_flag;
    logic        clr_status_p2;
    logic        clr_error_p2;
    logic        clr_done_p2;
    logic [22:0] widx;
    logic [63:0] word;
    logic [31:0] half;
    logic [63:0] rd_next;
    logic [63:0] req_next;
    logic        wr;
    logic [63:0] cnt [NUM_COUNTERS];

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        assign cnt[i] = counters_in[64*i +: 64];
    end

    assign busy = vld_p1 | mmio_ack;

    // Stage 1: capture the request; anything arriving while busy is dropped
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            vld_p1         <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            vld_p1 <= mmio_in_valid & ~busy;
            if (mmio_in_valid & busy)
                protocol_error <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mmio_in_valid & ~busy)
            req_p1 <= {mmio_in_cfg, mmio_in_read, mmio_in_dw, mmio_in_addr, mmio_in_data};
    end

    // Word index ignores address bit 0; bit 0 only picks the 32-bit half
    assign widx = req_p1.addr[23:1];
    assign wr   = vld_p1 & ~req_p1.read & ~req_p1.cfg;

    always_comb begin
        word = '0;
        if (req_p1.cfg) begin
            if (widx == '0)
                word = AFU_DESCRIPTOR;
        end else begin
            case (widx)
                ADDR_ALGO_STATUS[23:1]:      word = status_reg;
                ADDR_ALGO_REQUEST[23:1]:     word = algo_request;
                ADDR_ERROR_REG[23:1]:        word = error_reg;
                ADDR_AFU_STATUS[23:1]:       word = {63'b0, afu_running_in};
                ADDR_ALGO_RUNNING[23:1]:     word = {63'b0, afu_running_in};
                ADDR_ALGO_STATUS_DONE[23:1]: word = {63'b0, done_flag};
                ADDR_DONE_COUNT[23:1]:       word = cnt[CNT_DONE];
                ADDR_DONE_RESTART[23:1]:     word = cnt[CNT_DONE_RESTART];
                ADDR_DONE_PREFETCH[23:1]:    word = cnt[CNT_DONE_PREFETCH];
                ADDR_PAGED[23:1]:            word = cnt[CNT_PAGED];
                ADDR_FLUSHED[23:1]:          word = cnt[CNT_FLUSHED];
                ADDR_AERROR[23:1]:           word = cnt[CNT_AERROR];
                ADDR_DERROR[23:1]:           word = cnt[CNT_DERROR];
                ADDR_FAILED[23:1]:           word = cnt[CNT_FAILED];
                ADDR_FAULT[23:1]:            word = cnt[CNT_FAULT];
                ADDR_NRES[23:1]:             word = cnt[CNT_NRES];
                ADDR_NLOCK[23:1]:            word = cnt[CNT_NLOCK];
                default:                     word = '0;
            endcase
        end
    end

    // Host bit 0 is the MSB, so an even address selects the upper Verilog half
    assign half    = req_p1.addr[0] ? word[31:0] : word[63:32];
    assign rd_next = ~req_p1.read ? 64'b0 : (req_p1.dw ? word : {half, half});

    always_comb begin
        req_next = algo_request;
        if (req_p1.dw)
            req_next = req_p1.data;
        else if (req_p1.addr[0])
            req_next[31:0] = req_p1.data[31:0];
        else
            req_next[63:32] = req_p1.data[63:32];
    end

    // Stage 2: registered ack, read data and write strobes
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            mmio_ack           <= 1'b0;
            mmio_rdata         <= '0;
            mmio_rdata_parity  <= 1'b0;
            algo_request       <= '0;
            algo_request_valid <= 1'b0;
            clr_status_p2      <= 1'b0;
            clr_error_p2       <= 1'b0;
            clr_done_p2        <= 1'b0;
        end else begin
            mmio_ack           <= vld_p1;
            mmio_rdata         <= vld_p1 ? rd_next : 64'b0;
            mmio_rdata_parity  <= vld_p1 ? odd_parity(rd_next) : 1'b0;
            algo_request_valid <= wr && (widx == ADDR_ALGO_REQUEST[23:1]);
            if (wr && (widx == ADDR_ALGO_REQUEST[23:1]))
                algo_request <= req_next;
            clr_status_p2 <= wr && (widx == ADDR_ALGO_STATUS_ACK[23:1]);
            clr_error_p2  <= wr && (widx == ADDR_ERROR_REG_ACK[23:1]);
            clr_done_p2   <= wr && (widx == ADDR_ALGO_STATUS_DONE_ACK[23:1]);
        end
    end

    // Acks take effect at the end of the ack cycle; new events always win
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            status_reg <= '0;
            error_reg  <= '0;
            done_flag  <= 1'b0;
        end else begin
            status_reg <= algo_status_valid_in ? algo_status_in
                                               : (clr_status_p2 ? 64'b0 : status_reg);
            error_reg  <= (clr_error_p2 ? 64'b0 : error_reg) | error_in;
            done_flag  <= algo_done_in | (done_flag & ~clr_done_p2);
        end
    end

endmodule

// File: doc/mmio_register_responder.md
Name: mmio_register_responder

Overview:
- AFU-side responder for host MMIO accesses from the PSL; the host is the initiator.
- Decodes the shared MMIO register map: ALGO_REQUEST, ALGO_STATUS, ERROR_REG, AFU_STATUS, ALGO_RUNNING, the *_ACK registers, ALGO_STATUS_DONE and the eleven performance counters.
- Returns read data with a fixed-latency ack and forwards host writes to the CU-control as single-cycle strobes.
- Sits between the PSL MMIO interface and afu_control/cu_control.

Parameters:
- AFU_DESCRIPTOR, 64'h0000_0000_0001_0001, value returned for config-space read at word address 0.
- NUM_COUNTERS, 11, number of 64-bit counter inputs; order is DONE, DONE_RESTART, DONE_PREFETCH, PAGED, FLUSHED, AERROR, DERROR, FAILED, FAULT, NRES, NLOCK.

Ports:
- clock  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- mmio_in_valid  in  1  request strobe, one cycle.
- mmio_in_cfg  in  1  config-space access.
- mmio_in_read  in  1  1=read, 0=write.
- mmio_in_dw  in  1  1=64-bit access, 0=32-bit access.
- mmio_in_addr  in  24  word address.
- mmio_in_data  in  64  write data [0:63].
- mmio_ack  out  1  completion strobe.
- mmio_rdata  out  64  read data, valid with mmio_ack.
- mmio_rdata_parity  out  1  odd parity over mmio_rdata.
- algo_request  out  64  last value written to ALGO_REQUEST.
- algo_request_valid  out  1  one-cycle pulse on each ALGO_REQUEST write.
- algo_status_in  in  64  CU status word.
- algo_status_valid_in  in  1  latch algo_status_in.
- algo_done_in  in  1  pulse: kernel done.
- afu_running_in  in  1  job running.
- error_in  in  64  per-bit error events.
- counters_in  in  64*NUM_COUNTERS  counter values.
- protocol_error  out  1  sticky: request received while busy.

Behaviour:
- Reset: all outputs 0. Internal status/error/done registers 0. Pipeline empty.
- Reset mid-transaction: the transaction is dropped; no ack is issued after rstn deasserts.

Pipeline:
- Request at cycle T. Stage 1 registers the request fields at T+1. Stage 2 decodes and drives mmio_ack=1 with mmio_rdata at T+2.
- Fixed latency 2 for every access: read, write, cfg, or unmapped.
- Busy = stage 1 or stage 2 occupied. mmio_in_valid while busy: request dropped, no ack, protocol_error set until reset.

Register decode (word address; each register is 64 bits at an even word address):
- ALGO_STATUS (0xFFFFFE) read: status_reg.
  - status_reg latches algo_status_in when algo_status_valid_in=1.
  - A write to ALGO_STATUS_ACK (0xFFFFF4) clears status_reg to 0.
  - Clear and a same-cycle latch: the latch wins.
- ALGO_REQUEST (0xFFFFFC) write: algo_request <= data; algo_request_valid=1 in the ack cycle. Read: returns algo_request.
- ERROR_REG (0xFFFFFA) read: error_reg.
  - Every cycle: error_reg <= (clear ? 0 : error_reg) | error_in.
  - clear = a write to ERROR_REG_ACK (0xFFFFF2) in its ack cycle. Same-cycle new error bits survive the clear.
- AFU_STATUS (0xFFFFF8) read: {63'b0, afu_running_in}.
- ALGO_RUNNING (0xFFFFF6) read: {63'b0, afu_running_in}.
- ALGO_STATUS_DONE (0xFFFFF0) read: {63'b0, done_flag}.
  - done_flag is set by algo_done_in.
  - A write to ALGO_STATUS_DONE_ACK (0xFFFFEE) clears it; set wins on a same-cycle conflict.
- Counter registers read counters_in, sampled in stage 2:
  - DONE_COUNT 0xFFFFEC, DONE_RESTART 0xFFFFEA, DONE_PREFETCH 0xFFFFD8, PAGED 0xFFFFE8, FLUSHED 0xFFFFE6.
  - AERROR 0xFFFFE4, DERROR 0xFFFFE2, FAILED 0xFFFFE0, FAULT 0xFFFFDE, NRES 0xFFFFDC, NLOCK 0xFFFFDA.
- Writes to read-only or unmapped addresses: acked, no effect. Unmapped reads return 0.

Access width:
- 64-bit access: address bit 0 is ignored.
- 32-bit read: half selected by address bit 0 (0 → bits [0:31], 1 → [32:63]), duplicated into both halves of mmio_rdata.
- 32-bit write to ALGO_REQUEST: updates only the addressed half. 32-bit writes to *_ACK registers act as a full ack.

Config space:
- mmio_in_cfg read of word address 0 or 1 returns AFU_DESCRIPTOR (halves per the 32-bit rules); all other cfg reads return 0.
- cfg writes: acked, no effect.

Parity: mmio_rdata_parity = ~^mmio_rdata, registered alongside the data.

Decomposition:
- Register addresses, NUM_COUNTERS and the counter ordering go in GLOBALS_PKG.
- Add an mmio_req_t struct (cfg, read, dw, addr, data) to GLOBALS_PKG for the stage registers.
- No sub-module; decode and pipeline stay in one module. An odd-parity function belongs in the package.

Test Plan:
- Reset, then 64-bit read of ALGO_STATUS after algo_status_in=64'hDEAD_BEEF_0000_0001 is latched → ack exactly 2 cycles after the request; rdata=64'hDEAD_BEEF_0000_0001; parity=~^rdata.
- 64-bit write of 64'h1 to ALGO_REQUEST → algo_request=1, algo_request_valid high for exactly 1 cycle, aligned with the ack.
- error_in pulses bit 5; host reads ERROR_REG → bit 5 set. Write ERROR_REG_ACK in the same cycle as an error_in bit 9 pulse → later read returns only bit 9.
- 32-bit read of DONE_COUNT at 0xFFFFEC and 0xFFFFED with counter=64'h0000_0007_0000_0003 → rdata 64'h0000_0007_0000_0007, then 64'h0000_0003_0000_0003.
- Second mmio_in_valid 1 cycle after the first → exactly one ack; protocol_error=1 until reset. Cfg read at address 0 → AFU_DESCRIPTOR. Unmapped read → 0 with ack.
- Request issued, then rstn asserted at T+1 → no ack after release; all outputs 0.
